// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, reset constants and the queue entry type for the IF stage.
package ifu_pkg;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned INSTR_W     = 16;
  localparam logic [ADDR_W-1:0] PC_STEP  = 16'd4;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0004;
  localparam int unsigned QUEUE_DEPTH = 2;
  localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory read port, decode handshake and redirect port of the fetch stage.
interface instruction_fetch_unit_if;
  import ifu_pkg::*;

  logic               memRequest;
  logic [ADDR_W-1:0]  memAddress;
  logic [INSTR_W-1:0] memInstruction;
  logic               memValid;
  logic               branchTaken;
  logic [ADDR_W-1:0]  branchTarget;
  logic               instrValid;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  instrPc;
  logic               instrReady;

  modport master (
    output memRequest, memAddress, instrValid, instruction, instrPc,
    input  memInstruction, memValid, branchTaken, branchTarget, instrReady
  );

  modport slave (
    input  memRequest, memAddress, instrValid, instruction, instrPc,
    output memInstruction, memValid, branchTaken, branchTarget, instrReady
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// In-order instruction queue; request addresses wait in a tag FIFO until their response lands.
module fetch_queue
  import ifu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               tag_push,
  input  logic [ADDR_W-1:0]  tag,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic               head_valid,
  output logic [CNT_W-1:0]   count
);
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

  fetch_entry_t      entries [QUEUE_DEPTH];
  logic [ADDR_W-1:0] tags    [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [CNT_W-1:0]  cnt;
  logic              pop_ok;

  always_comb begin
    pop_ok     = pop && (cnt != '0);
    head       = entries[rd_ptr];
    head_valid = (cnt != '0);
    count      = cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tag_wr <= '0;
      tag_rd <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tag_wr <= '0;
      tag_rd <= '0;
      cnt    <= '0;
    end else begin
      if (tag_push) tag_wr <= tag_wr + 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        tag_rd <= tag_rd + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (tag_push) tags[tag_wr] <= tag;
    if (push) entries[wr_ptr] <= '{instr: push_instr, pc: tags[tag_rd]};
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues credit-limited reads and handles redirects.
// Build option FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets.
module instruction_fetch_unit
  import ifu_pkg::*;
(
  input  logic clock,
  input  logic reset,
  instruction_fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic misalignFault
`endif
);
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  inflight, discard, owed, count;
  logic [CNT_W:0]    occupancy;
  logic              pop, issue, resp_arrive, resp_keep, resp_drop;
  logic              misaligned, fault, head_valid;
  fetch_entry_t      head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = bus.branchTaken && (bus.branchTarget[1:0] != 2'b00);
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           fault <= 1'b0;
    else if (misaligned) fault <= 1'b1;
  end
  assign misalignFault = fault;
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  // Credits count queued entries plus responses still owed, net of this cycle's pop.
  always_comb begin
    pop         = head_valid && bus.instrReady;
    occupancy   = {1'b0, count} + {1'b0, inflight} - (CNT_W+1)'(pop);
    issue       = !reset && !bus.branchTaken && !fault
                  && (occupancy < (CNT_W+1)'(QUEUE_DEPTH));
    resp_arrive = bus.memValid && ((inflight != '0) || (discard != '0));
    resp_drop   = resp_arrive && (discard != '0);
    resp_keep   = resp_arrive && (discard == '0);
    owed        = inflight + discard - CNT_W'(resp_arrive);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (bus.branchTaken) begin
      inflight <= '0;
      discard  <= owed;
      if (!misaligned) pc <= bus.branchTarget & ~ADDR_W'(3);
    end else begin
      discard  <= discard - CNT_W'(resp_drop);
      inflight <= inflight + CNT_W'(issue) - CNT_W'(resp_keep);
      if (issue) pc <= pc + PC_STEP;
    end
  end

  fetch_queue u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (bus.branchTaken),
    .tag_push   (issue),
    .tag        (pc),
    .push       (resp_keep && !bus.branchTaken),
    .push_instr (bus.memInstruction),
    .pop        (pop && !bus.branchTaken),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  always_comb begin
    bus.memRequest  = issue;
    bus.memAddress  = pc;
    bus.instrValid  = head_valid;
    bus.instruction = head_valid ? head.instr : '0;
    bus.instrPc     = head_valid ? head.pc    : '0;
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed vector table, corner sequences, then randomized traffic vs a queue model.
module tb_instruction_fetch_unit;
  import ifu_pkg::*;

  localparam logic [15:0] KEY = 16'h5A5A;

  logic clock = 1'b0;
  logic reset;
  instruction_fetch_unit_if bus();

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_fault;
  instruction_fetch_unit dut (.clock(clock), .reset(reset), .bus(bus), .misalignFault(misalign_fault));
`else
  instruction_fetch_unit dut (.clock(clock), .reset(reset), .bus(bus));
`endif

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  typedef struct {
    logic [15:0] addr;
    bit          drop;
  } pend_t;

  typedef struct {
    logic        ready;
    logic        br;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
  } vec_t;

  ent_t  mq[$];
  pend_t pend[$];
  logic [15:0] mpc;
  bit          mfault;

  logic        mem_pend, mem_next;
  logic [15:0] mem_addr, mem_next_addr;

  logic        s_req, s_valid;
  logic [15:0] s_addr, s_pc, s_instr;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    pend.delete();
    mpc    = 16'h0004;
    mfault = 1'b0;
  endfunction

  // Entered at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic ready, input logic br, input logic [15:0] tgt, input logic bad);
    logic        e_valid, e_req, pop;
    logic [15:0] e_pc, e_instr;
    int          live;
    pend_t       p;
    bus.instrReady   = ready;
    bus.branchTaken  = br;
    bus.branchTarget = tgt;
    if (mem_pend) begin
      bus.memValid       = 1'b1;
      bus.memInstruction = mem_addr ^ KEY;
    end else if (bad) begin
      bus.memValid       = 1'b1;
      bus.memInstruction = 16'($urandom);
    end else begin
      bus.memValid       = 1'b0;
      bus.memInstruction = '0;
    end
    @(negedge clock);

    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc : 16'h0000;
    e_instr = e_valid ? mq[0].instr : 16'h0000;
    pop     = e_valid && ready;
    live    = 0;
    foreach (pend[i]) if (!pend[i].drop) live++;
    e_req   = !br && !mfault && ((mq.size() + live - int'(pop)) < QUEUE_DEPTH);

    s_req = bus.memRequest; s_addr = bus.memAddress; s_valid = bus.instrValid;
    s_pc  = bus.instrPc;    s_instr = bus.instruction;
    chk("memRequest", 16'(s_req), 16'(e_req));
    chk("memAddress", s_addr, mpc);
    chk("instrValid", 16'(s_valid), 16'(e_valid));
    chk("instrPc", s_pc, e_pc);
    chk("instruction", s_instr, e_instr);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalignFault", 16'(misalign_fault), 16'(mfault));
`endif

    mem_next      = bus.memRequest;
    mem_next_addr = bus.memAddress;

    if (pop && !br) void'(mq.pop_front());
    if (bus.memValid && pend.size() != 0) begin
      p = pend.pop_front();
      if (!br && !p.drop) mq.push_back('{bus.memInstruction, p.addr});
    end
    if (br) begin
      mq.delete();
      foreach (pend[i]) pend[i].drop = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) mfault = 1'b1;
      else mpc = tgt & 16'hFFFC;
`else
      mpc = tgt & 16'hFFFC;
`endif
    end else if (e_req) begin
      pend.push_back('{mpc, 1'b0});
      mpc = mpc + 16'd4;
    end

    @(posedge clock);
    #1;
    mem_pend = mem_next;
    mem_addr = mem_next_addr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.branchTaken = 1'b0; bus.branchTarget = '0;
    bus.memValid = 1'b0; bus.memInstruction = '0; bus.instrReady = 1'b0;
    #2;
    chk("rst_memRequest", 16'(bus.memRequest), 16'h0000);
    chk("rst_memAddress", bus.memAddress, 16'h0004);
    chk("rst_instrValid", 16'(bus.instrValid), 16'h0000);
    chk("rst_instruction", bus.instruction, 16'h0000);
    chk("rst_instrPc", bus.instrPc, 16'h0000);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_misalignFault", 16'(misalign_fault), 16'h0000);
`endif
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_pend = 1'b0;
    mem_addr = '0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[13];
    logic [15:0] wrap_exp[4];
    logic [15:0] tgt;
    int          r;

    // Stall for six cycles, resume, then redirect while popping.
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h000C, 1'b1, 16'h0004};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h000C, 1'b1, 16'h0004};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h000C, 1'b1, 16'h0004};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h000C, 1'b1, 16'h0004};
    tbl[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h000C, 1'b1, 16'h0004};
    tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b1, 16'h0008};
    tbl[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0014, 1'b1, 16'h000C};
    tbl[9]  = '{1'b1, 1'b1, 16'h0040, 1'b0, 16'h0018, 1'b1, 16'h0010};
    tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b0, 16'h0000};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0048, 1'b1, 16'h0040};
    wrap_exp[0] = 16'hFFF8; wrap_exp[1] = 16'hFFFC;
    wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0004;

    do_reset();

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].ready, tbl[i].br, tbl[i].tgt, 1'b0);
      chk($sformatf("tbl%0d_req", i), 16'(s_req), 16'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 16'(s_valid), 16'(tbl[i].valid));
      chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].valid ? (tbl[i].pc ^ KEY) : 16'h0000);
    end

    cycle(1'b1, 1'b1, 16'hFFF8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 16'h0000, 1'b0);
      chk("wrap_req", 16'(s_req), 16'h0001);
      chk("wrap_addr", s_addr, wrap_exp[i]);
    end

    cycle(1'b1, 1'b1, 16'h0042, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_fault", 16'(misalign_fault), 16'h0001);
    chk("trap_req", 16'(s_req), 16'h0000);
`else
    chk("misalign_addr", s_addr, 16'h0040);
    chk("misalign_req", 16'(s_req), 16'h0001);
`endif
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b0);

    // Mid-trace reset; a stray response right after release must be ignored.
    do_reset();
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("post_rst_addr", s_addr, 16'h0004);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("post_rst_pc", s_pc, 16'h0004);

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(3);
      if (r == 0)      tgt = 16'hFFF0 + 16'($urandom_range(3) * 4);
      else if (r == 3) tgt = 16'($urandom);
      else             tgt = 16'($urandom) & 16'hFFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = tgt & 16'hFFFC;
`endif
      cycle(($urandom_range(3) != 0), ($urandom_range(11) == 0), tgt, ($urandom_range(9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
